rx_frame_ctrl: RTL and testbench
================================

// Module: rx_frame_ctrl
// PURPOSE
//  Frame sequencer beside the UART receive path. Counts bytes on the per-byte pulse,
//  closes a frame after a programmable idle gap (in baud periods), and queues one
//  28-bit frame record per closed frame in a small FIFO.
//  The frame record holds the byte count plus the millisecond/0.1 ms stamp of the last byte.
//  The register interface pops records with a one-clock active-low read strobe.
// PARAMETERS
//  DEPTH   4    frame-record FIFO entries; power of 2, range 2..16
//  AW      2    pointer width = log2(DEPTH)
// PORTS
//  clk                     in   1   system clock
//  rst                     in   1   asynchronous, active-low reset
//  p_Enable_i              in   1   receiver enable; low = abort frame, hold IDLE
//  p_FrameFunctionEnable_i in   1   frame function enable; low = same as p_Enable_i low
//  n_Clr_i                 in   1   active-low synchronous clear of FIFO, over flag and frame in progress
//  Byte_Synch_i            in   1   one-clk pulse per received byte
//  BaudSig_i               in   1   one-clk pulse per baud period
//  GapBaudNum_i            in   8   idle baud periods that close a frame; 0 is treated as 1
//  acqurate_stamp_i        in   4   0.1 ms stamp, range 0..9
//  millisecond_stamp_i     in   12  ms stamp, range 0..999
//  n_RxFrameInfo_Rd_i      in   1   active-low pop strobe, 1 clk wide
//  RxFrameInfo_o           out  28  head record {cnt[27:16], ms[15:4], acq[3:0]}; 0 when empty
//  p_RxFrame_Empty_o       out  1   FIFO empty
//  p_RxFrame_Full_o        out  1   FIFO full
//  p_RxFrameOver_o         out  1   sticky: frame dropped because FIFO was full
//  p_FrameEnd_o            out  1   one-clk pulse in the CLOSE cycle
//  FrameLevel_o            out  AW+1  records held
// BEHAVIOUR
//  Reset values: all outputs 0 except p_RxFrame_Empty_o=1. Internal state: IDLE, counters 0.
//  FSM states:
//   IDLE  : Byte_Synch -> RECV; cnt=1; latch stamps; gap=0.
//   RECV  : Byte_Synch -> cnt+1 (saturates at 12'hFFF); re-latch stamps; gap=0.
//           Else on BaudSig -> gap+1.
//           When gap reaches max(GapBaudNum_i,1) -> CLOSE.
//           Byte_Synch and BaudSig in the same cycle: the byte wins, gap cleared.
//   CLOSE : 1 cycle. Pulse p_FrameEnd_o.
//           Write {cnt, ms, acq} if not full; if full, set p_RxFrameOver_o and drop the record.
//           Next state is IDLE; if Byte_Synch is asserted in this cycle, next state is RECV with cnt=1.
//  Latency: record is visible and Empty deasserts on the clock after the CLOSE cycle.
//  Record format: stamps are those latched at the last byte, not at close time.
//  Pop: n_RxFrameInfo_Rd_i low and not empty -> rd_ptr+1 at that edge; next head shows next cycle.
//       Pop when empty is ignored.
//  Show-ahead FIFO: RxFrameInfo_o = mem[rd_ptr] when not empty.
//  Same-cycle write and pop: both are performed; level unchanged; no overflow even if full.
//  Pointers are AW+1 bits and wrap naturally; full = MSBs differ and LSBs are equal.
//  Enable low in any state: next state IDLE, partial frame discarded, FIFO contents kept.
//   Pops remain serviced.
//  n_Clr_i low: FIFO emptied, p_RxFrameOver_o cleared, FSM to IDLE.
//   Takes priority over a write or pop in the same cycle.
//  Over flag is cleared only by n_Clr_i or rst.
//  Reset mid-frame: everything returns immediately to reset values; no record is produced.
// STRUCTURE
//  Shared package rx_frame_pkg holds:
//   - state encodings FR_IDLE=3'b001, FR_RECV=3'b010, FR_CLOSE=3'b100
//   - INFO_W=28 and the field offsets CNT_LSB=16, MS_LSB=4
//  Sub-module frame_info_fifo: parameterised DEPTH x INFO_W show-ahead sync FIFO
//   with flags and level.
//  Top level holds the FSM, byte counter, gap counter and stamp latches.
// TESTING
//  1 Reset: after rst release, Empty=1, Over=0, RxFrameInfo_o=0, Level=0.
//  2 3 bytes, stamps ms=100 and acq=7 at the last byte, Gap=4:
//    FrameEnd exactly on the 4th BaudSig after the last byte; record=={12'd3,12'd100,4'd7}.
//  3 Gap=0: frame closes on the 1st BaudSig after the byte.
//    Byte coincident with a BaudSig: gap is reset, no close.
//  4 DEPTH=4: close 5 frames with no pops.
//    Full=1 after the 4th; 5th sets Over=1; 5th record is lost; 4 pops return frames 1..4.
//  5 Full FIFO, CLOSE and pop in the same cycle: Over stays 0, Level stays 4,
//    and the new record appears last.
//  6 Drop p_FrameFunctionEnable_i mid-frame: no FrameEnd, no record.
//    n_Clr_i with 2 records queued: Empty=1 and Level=0 on the next clock.

Source files
------------

// File: rtl/rx_frame_ctrl_pkg.sv
// Shared definitions for the receive frame sequencer.
//   fr_state_e  : one-hot FSM encodings
//   INFO_W      : frame record width {cnt, ms, acq}
//   CNT_LSB     : bit offset of the byte count field
//   MS_LSB      : bit offset of the millisecond stamp field
//   pack_info() : assembles a frame record from its fields
package rx_frame_pkg;

  typedef enum logic [2:0] {
    FR_IDLE  = 3'b001,
    FR_RECV  = 3'b010,
    FR_CLOSE = 3'b100
  } fr_state_e;

  localparam int INFO_W  = 28;
  localparam int CNT_LSB = 16;
  localparam int MS_LSB  = 4;

  function automatic logic [INFO_W-1:0] pack_info(input logic [11:0] cnt,
                                                  input logic [11:0] ms,
                                                  input logic [3:0]  acq);
    logic [INFO_W-1:0] info;
    info = '0;
    info[INFO_W-1:CNT_LSB] = cnt;
    info[CNT_LSB-1:MS_LSB] = ms;
    info[MS_LSB-1:0]       = acq;
    return info;
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Register-side frame record interface.
//   n_RxFrameInfo_Rd_i : active-low one-clock pop strobe (register side drives)
//   RxFrameInfo_o      : head record, 0 when empty
//   p_RxFrame_Empty_o  : FIFO empty
//   p_RxFrame_Full_o   : FIFO full
//   p_RxFrameOver_o    : sticky overflow, a closed frame was dropped
//   FrameLevel_o       : number of records held
// master = register file side, slave = rx_frame_ctrl.
interface rx_frame_ctrl_if #(
  parameter int AW = 2
);
  import rx_frame_pkg::*;

  logic              n_RxFrameInfo_Rd_i;
  logic [INFO_W-1:0] RxFrameInfo_o;
  logic              p_RxFrame_Empty_o;
  logic              p_RxFrame_Full_o;
  logic              p_RxFrameOver_o;
  logic [AW:0]       FrameLevel_o;

  modport master (
    output n_RxFrameInfo_Rd_i,
    input  RxFrameInfo_o, p_RxFrame_Empty_o, p_RxFrame_Full_o,
           p_RxFrameOver_o, FrameLevel_o
  );

  modport slave (
    input  n_RxFrameInfo_Rd_i,
    output RxFrameInfo_o, p_RxFrame_Empty_o, p_RxFrame_Full_o,
           p_RxFrameOver_o, FrameLevel_o
  );

endinterface

// File: rtl/rx_frame_ctrl_fifo.sv
// frame_info_fifo: DEPTH x INFO_W show-ahead synchronous FIFO for frame records.
//   clk, rst : clock, async active-low reset
//   clr_n    : sync clear of contents and overflow flag, beats write/pop
//   wr, din  : write request and record
//   rd_n     : active-low pop strobe, ignored when empty
//   dout     : head record, 0 when empty
//   empty, full, over, level : status
module frame_info_fifo
  import rx_frame_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_n,
  input  logic              wr,
  input  logic [INFO_W-1:0] din,
  input  logic              rd_n,
  output logic [INFO_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              over,
  output logic [AW:0]       level
);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [INFO_W-1:0] mem [DEPTH];
  logic              rd_fire, wr_fire, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the head slot, so a write into a full FIFO
  // lands in the slot being vacated and nothing is lost.
  assign rd_fire = !rd_n && !empty;
  assign wr_fire = wr && (!full || rd_fire);
  assign drop    = wr && full && !rd_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      over   <= 1'b0;
    end else if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      over   <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      if (drop)    over   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_n && wr_fire) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: frame sequencer beside the UART receive path.
// Counts bytes, closes a frame after an idle gap of baud periods and queues
// a {cnt, ms, acq} record per closed frame.
//   clk, rst                : clock, async active-low reset
//   p_Enable_i              : receiver enable, low aborts frame
//   p_FrameFunctionEnable_i : frame function enable, low aborts frame
//   n_Clr_i                 : active-low sync clear of FIFO, over flag, frame
//   Byte_Synch_i            : one pulse per received byte
//   BaudSig_i               : one pulse per baud period
//   GapBaudNum_i            : idle baud periods closing a frame (0 acts as 1)
//   acqurate_stamp_i        : 0.1 ms stamp
//   millisecond_stamp_i     : ms stamp
//   p_FrameEnd_o            : pulse in the CLOSE cycle
//   bus                     : record read interface (slave side)
//
// state    | meaning
// FR_IDLE  | no frame in progress, waiting for first byte
// FR_RECV  | counting bytes, counting idle baud periods
// FR_CLOSE | one cycle: push record (or flag overflow), pulse frame end
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_Enable_i,
  input  logic        p_FrameFunctionEnable_i,
  input  logic        n_Clr_i,
  input  logic        Byte_Synch_i,
  input  logic        BaudSig_i,
  input  logic [7:0]  GapBaudNum_i,
  input  logic [3:0]  acqurate_stamp_i,
  input  logic [11:0] millisecond_stamp_i,
  output logic        p_FrameEnd_o,
  rx_frame_ctrl_if.slave bus
);

  fr_state_e   state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [11:0] ms_q, ms_d;
  logic [3:0]  acq_q, acq_d;
  logic        run, wr;
  logic [7:0]  gap_lim;
  logic [8:0]  gap_inc;

  assign run     = p_Enable_i && p_FrameFunctionEnable_i && n_Clr_i;
  assign gap_lim = (GapBaudNum_i == 8'd0) ? 8'd1 : GapBaudNum_i;
  assign gap_inc = {1'b0, gap_q} + 9'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FR_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ms_q    <= '0;
      acq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ms_q    <= ms_d;
      acq_q   <= acq_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    ms_d         = ms_q;
    acq_d        = acq_q;
    p_FrameEnd_o = 1'b0;
    wr           = 1'b0;
    if (!run) begin
      state_d = FR_IDLE;
      cnt_d   = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        FR_IDLE: begin
          if (Byte_Synch_i) begin
            state_d = FR_RECV;
            cnt_d   = 12'd1;
            gap_d   = '0;
            ms_d    = millisecond_stamp_i;
            acq_d   = acqurate_stamp_i;
          end
        end
        FR_RECV: begin
          // a byte outranks a coincident baud tick and restarts the gap
          if (Byte_Synch_i) begin
            if (cnt_q != 12'hFFF) cnt_d = cnt_q + 12'd1;
            gap_d = '0;
            ms_d  = millisecond_stamp_i;
            acq_d = acqurate_stamp_i;
          end else if (BaudSig_i) begin
            // >= so a limit lowered mid-frame still closes the frame
            if (gap_inc >= {1'b0, gap_lim}) begin
              state_d = FR_CLOSE;
              gap_d   = '0;
            end else begin
              gap_d = gap_inc[7:0];
            end
          end
        end
        FR_CLOSE: begin
          p_FrameEnd_o = 1'b1;
          wr           = 1'b1;
          gap_d        = '0;
          if (Byte_Synch_i) begin
            state_d = FR_RECV;
            cnt_d   = 12'd1;
            ms_d    = millisecond_stamp_i;
            acq_d   = acqurate_stamp_i;
          end else begin
            state_d = FR_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = FR_IDLE;
          cnt_d   = '0;
          gap_d   = '0;
        end
      endcase
    end
  end

  frame_info_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr_n (n_Clr_i),
    .wr    (wr),
    .din   (pack_info(cnt_q, ms_q, acq_q)),
    .rd_n  (bus.n_RxFrameInfo_Rd_i),
    .dout  (bus.RxFrameInfo_o),
    .empty (bus.p_RxFrame_Empty_o),
    .full  (bus.p_RxFrame_Full_o),
    .over  (bus.p_RxFrameOver_o),
    .level (bus.FrameLevel_o)
  );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: stimulus pushes expected records,
// a negedge monitor compares the head record on every accepted pop and
// counts frame-end pulses.
module tb_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_Enable_i = 1'b1;
  logic        p_FrameFunctionEnable_i = 1'b1;
  logic        n_Clr_i = 1'b1;
  logic        Byte_Synch_i = 1'b0;
  logic        BaudSig_i = 1'b0;
  logic [7:0]  GapBaudNum_i = 8'd4;
  logic [3:0]  acqurate_stamp_i = 4'd0;
  logic [11:0] millisecond_stamp_i = 12'd0;
  logic        p_FrameEnd_o;

  rx_frame_ctrl_if #(.AW(2)) bus ();

  rx_frame_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .p_Enable_i              (p_Enable_i),
    .p_FrameFunctionEnable_i (p_FrameFunctionEnable_i),
    .n_Clr_i                 (n_Clr_i),
    .Byte_Synch_i            (Byte_Synch_i),
    .BaudSig_i               (BaudSig_i),
    .GapBaudNum_i            (GapBaudNum_i),
    .acqurate_stamp_i        (acqurate_stamp_i),
    .millisecond_stamp_i     (millisecond_stamp_i),
    .p_FrameEnd_o            (p_FrameEnd_o),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fe_seen  = 0;
  int fe_exp   = 0;
  logic [27:0] rec_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] rec(input int n, input int ms, input int acq);
    return {12'(n), 12'(ms), 4'(acq)};
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      if (p_FrameEnd_o) fe_seen++;
      if (!bus.n_RxFrameInfo_Rd_i && !bus.p_RxFrame_Empty_o) begin
        if (rec_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got 0x%0h expected no record", bus.RxFrameInfo_o);
        end else begin
          check("pop_record", {4'd0, bus.RxFrameInfo_o}, {4'd0, rec_q.pop_front()});
        end
      end
    end
  end

  task automatic cyc(input logic b, input logic d);
    Byte_Synch_i = b;
    BaudSig_i    = d;
    @(posedge clk); #1;
    Byte_Synch_i = 1'b0;
    BaudSig_i    = 1'b0;
  endtask

  task automatic byte_at(input int ms, input int acq);
    millisecond_stamp_i = 12'(ms);
    acqurate_stamp_i    = 4'(acq);
    cyc(1'b1, 1'b0);
  endtask

  task automatic pop();
    bus.n_RxFrameInfo_Rd_i = 1'b0;
    @(posedge clk); #1;
    bus.n_RxFrameInfo_Rd_i = 1'b1;
  endtask

  // assumes GapBaudNum_i == 1: one baud tick after the last byte closes
  task automatic send_frame(input int nb, input int ms, input int acq, input bit pop_at_close);
    for (int i = 0; i < nb; i++) byte_at(ms - nb + 1 + i, (i == nb - 1) ? acq : 0);
    cyc(1'b0, 1'b1);
    fe_exp++;
    if (pop_at_close) bus.n_RxFrameInfo_Rd_i = 1'b0;
    cyc(1'b0, 1'b0);
    bus.n_RxFrameInfo_Rd_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.n_RxFrameInfo_Rd_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b0, 1'b0);

    // 1 reset state
    check("rst_empty", 32'(bus.p_RxFrame_Empty_o), 32'd1);
    check("rst_full",  32'(bus.p_RxFrame_Full_o), 32'd0);
    check("rst_over",  32'(bus.p_RxFrameOver_o), 32'd0);
    check("rst_info",  32'(bus.RxFrameInfo_o), 32'd0);
    check("rst_level", 32'(bus.FrameLevel_o), 32'd0);
    check("rst_fe",    32'(p_FrameEnd_o), 32'd0);

    // 2 three bytes, gap 4, stamps of the last byte
    GapBaudNum_i = 8'd4;
    byte_at(90, 1);
    cyc(1'b0, 1'b0);
    byte_at(95, 3);
    byte_at(100, 7);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
    end
    check("gap4_no_early_close", 32'(p_FrameEnd_o), 32'd0);
    millisecond_stamp_i = 12'd555;
    acqurate_stamp_i    = 4'd2;
    cyc(1'b0, 1'b1);
    check("gap4_fe_on_4th_baud", 32'(p_FrameEnd_o), 32'd1);
    check("gap4_empty_in_close", 32'(bus.p_RxFrame_Empty_o), 32'd1);
    fe_exp++;
    rec_q.push_back(rec(3, 100, 7));
    cyc(1'b0, 1'b0);
    check("gap4_fe_one_cycle", 32'(p_FrameEnd_o), 32'd0);
    check("gap4_level", 32'(bus.FrameLevel_o), 32'd1);
    pop();
    check("gap4_empty_after_pop", 32'(bus.p_RxFrame_Empty_o), 32'd1);

    // 3 gap 0 acts as 1; byte coincident with baud restarts gap
    GapBaudNum_i = 8'd0;
    byte_at(5, 2);
    millisecond_stamp_i = 12'd6;
    acqurate_stamp_i    = 4'd3;
    cyc(1'b1, 1'b1);
    check("gap0_coincident_no_close", 32'(p_FrameEnd_o), 32'd0);
    cyc(1'b0, 1'b0);
    check("gap0_idle_no_close", 32'(p_FrameEnd_o), 32'd0);
    cyc(1'b0, 1'b1);
    check("gap0_close_1st_baud", 32'(p_FrameEnd_o), 32'd1);
    fe_exp++;
    rec_q.push_back(rec(2, 6, 3));
    cyc(1'b0, 1'b0);
    pop();

    // 4 overflow: 5 frames, no pops
    GapBaudNum_i = 8'd1;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) rec_q.push_back(rec(i, 200 + i, i));
      send_frame(i, 200 + i, i, 1'b0);
      if (i == 4) begin
        check("ovf_full_after_4", 32'(bus.p_RxFrame_Full_o), 32'd1);
        check("ovf_over_after_4", 32'(bus.p_RxFrameOver_o), 32'd0);
      end
    end
    check("ovf_over_after_5", 32'(bus.p_RxFrameOver_o), 32'd1);
    check("ovf_level_after_5", 32'(bus.FrameLevel_o), 32'd4);
    repeat (4) pop();
    check("ovf_empty_after_pops", 32'(bus.p_RxFrame_Empty_o), 32'd1);
    check("ovf_over_sticky", 32'(bus.p_RxFrameOver_o), 32'd1);
    n_Clr_i = 1'b0;
    cyc(1'b0, 1'b0);
    n_Clr_i = 1'b1;
    check("clr_over", 32'(bus.p_RxFrameOver_o), 32'd0);

    // 5 full FIFO, close and pop together
    for (int i = 1; i <= 4; i++) begin
      rec_q.push_back(rec(i + 1, 300 + i, i + 4));
      send_frame(i + 1, 300 + i, i + 4, 1'b0);
    end
    check("wrpop_full_before", 32'(bus.p_RxFrame_Full_o), 32'd1);
    rec_q.push_back(rec(7, 350, 9));
    send_frame(7, 350, 9, 1'b1);
    check("wrpop_over", 32'(bus.p_RxFrameOver_o), 32'd0);
    check("wrpop_level", 32'(bus.FrameLevel_o), 32'd4);
    repeat (4) pop();
    check("wrpop_empty_after", 32'(bus.p_RxFrame_Empty_o), 32'd1);

    // 6 abort via frame function enable, then clear with 2 queued
    byte_at(400, 1);
    byte_at(401, 2);
    p_FrameFunctionEnable_i = 1'b0;
    cyc(1'b0, 1'b0);
    p_FrameFunctionEnable_i = 1'b1;
    cyc(1'b0, 1'b1);
    check("abort_no_fe", 32'(p_FrameEnd_o), 32'd0);
    cyc(1'b0, 1'b0);
    check("abort_no_record", 32'(bus.p_RxFrame_Empty_o), 32'd1);
    send_frame(2, 500, 4, 1'b0);
    send_frame(3, 600, 5, 1'b0);
    check("clr_level_before", 32'(bus.FrameLevel_o), 32'd2);
    n_Clr_i = 1'b0;
    cyc(1'b0, 1'b0);
    n_Clr_i = 1'b1;
    check("clr_empty", 32'(bus.p_RxFrame_Empty_o), 32'd1);
    check("clr_level", 32'(bus.FrameLevel_o), 32'd0);
    check("clr_info",  32'(bus.RxFrameInfo_o), 32'd0);

    cyc(1'b0, 1'b0);
    check("frame_end_count", 32'(fe_seen), 32'(fe_exp));
    check("records_left", 32'(rec_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
